// File: rtl/sw_to_fw_cmd_decoder.sv
// Software-to-firmware command decoder: turns a 32-bit command word into a latched
// device select, a one-cycle op strobe and a payload, and muxes back the selected IP's read words.
module sw_to_fw_cmd_decoder #(
  parameter int NUM_FW = 15,
  parameter int CNT_W  = 16
) (
  input  logic                   fw_clk,
  input  logic                   fw_rst,
  input  logic [31:0]            sw_write32_0,
  input  logic                   sw_write32_0_valid,
  input  logic [32*NUM_FW-1:0]   fw_read_data32_all,
  input  logic [32*NUM_FW-1:0]   fw_read_status32_all,
  output logic [NUM_FW-1:0]      fw_dev_id_enable,
  output logic [13:0]            fw_op_code_strobe,
  output logic [23:0]            sw_write24_0,
  output logic [31:0]            sw_read32_0,
  output logic [31:0]            sw_read32_1,
  output logic [CNT_W-1:0]       cmd_count,
  output logic                   cmd_error
);

  localparam logic [3:0] LP_MAX_DEV = 4'(NUM_FW);
  localparam logic [3:0] LP_OP_CLR  = 4'd11;
  localparam logic [3:0] LP_OP_NOP  = 4'd13;

  logic [3:0]        w_dev, w_op, w_dev_m1;
  logic              w_dev_ok, w_op_ok, w_accept, w_illegal;
  logic [NUM_FW-1:0] w_enable_nxt;
  logic [13:0]       w_strobe_nxt;
  logic [31:0]       w_rd_data, w_rd_stat;

  logic [3:0]        r_dev_sel;
  logic [NUM_FW-1:0] r_enable;
  logic [13:0]       r_strobe;
  logic [23:0]       r_payload;
  logic [31:0]       r_rd_data, r_rd_stat;
  logic [CNT_W-1:0]  r_count;
  logic              r_error;

  assign w_dev     = sw_write32_0[31:28];
  assign w_op      = sw_write32_0[27:24];
  assign w_dev_m1  = w_dev - 4'd1;
  assign w_dev_ok  = (w_dev != 4'd0) && (w_dev <= LP_MAX_DEV);
  assign w_op_ok   = (w_op <= LP_OP_NOP);
  assign w_accept  = sw_write32_0_valid && w_dev_ok && w_op_ok;
  assign w_illegal = sw_write32_0_valid && !(w_dev_ok && w_op_ok);

  assign w_enable_nxt = NUM_FW'(1) << w_dev_m1;
  // op 13 still selects and counts, but has no strobe line of its own
  assign w_strobe_nxt = (w_op == LP_OP_NOP) ? 14'd0 : (14'd1 << w_op);

  // dev_sel = 0 matches no slice, so the read path returns 0 until something is selected
  always_comb begin
    w_rd_data = '0;
    w_rd_stat = '0;
    for (int i = 0; i < NUM_FW; i++) begin
      if (r_dev_sel == 4'(i + 1)) begin
        w_rd_data = fw_read_data32_all[32*i +: 32];
        w_rd_stat = fw_read_status32_all[32*i +: 32];
      end
    end
  end

  always_ff @(posedge fw_clk) begin
    if (fw_rst) begin
      r_dev_sel <= '0;
      r_enable  <= '0;
      r_strobe  <= '0;
      r_payload <= '0;
      r_rd_data <= '0;
      r_rd_stat <= '0;
      r_count   <= '0;
      r_error   <= 1'b0;
    end else begin
      r_strobe  <= '0;
      r_rd_data <= w_rd_data;
      r_rd_stat <= w_rd_stat;
      if (w_accept) begin
        r_dev_sel <= w_dev;
        r_enable  <= w_enable_nxt;
        r_strobe  <= w_strobe_nxt;
        r_payload <= sw_write32_0[23:0];
        r_count   <= r_count + CNT_W'(1);
        if (w_op == LP_OP_CLR) r_error <= 1'b0;
      end else if (w_illegal) begin
        r_error <= 1'b1;
      end
    end
  end

  assign fw_dev_id_enable  = r_enable;
  assign fw_op_code_strobe = r_strobe;
  assign sw_write24_0      = r_payload;
  assign sw_read32_0       = r_rd_data;
  assign sw_read32_1       = r_rd_stat;
  assign cmd_count         = r_count;
  assign cmd_error         = r_error;

endmodule

// File: tb/tb_sw_to_fw_cmd_decoder.sv
// Directed bench for sw_to_fw_cmd_decoder: reset, decode, read mux, illegal commands,
// back-to-back traffic, counter wrap and reset/valid collision.
module tb_sw_to_fw_cmd_decoder;
  localparam int NUM_FW = 15;
  localparam int CNT_W  = 16;

  logic                 fw_clk = 1'b0;
  logic                 fw_rst;
  logic [31:0]          sw_write32_0;
  logic                 sw_write32_0_valid;
  logic [32*NUM_FW-1:0] fw_read_data32_all;
  logic [32*NUM_FW-1:0] fw_read_status32_all;
  logic [NUM_FW-1:0]    fw_dev_id_enable;
  logic [13:0]          fw_op_code_strobe;
  logic [23:0]          sw_write24_0;
  logic [31:0]          sw_read32_0;
  logic [31:0]          sw_read32_1;
  logic [CNT_W-1:0]     cmd_count;
  logic                 cmd_error;

  int n_tests = 0;
  int n_fail  = 0;

  sw_to_fw_cmd_decoder #(.NUM_FW(NUM_FW), .CNT_W(CNT_W)) dut (
    .fw_clk(fw_clk), .fw_rst(fw_rst),
    .sw_write32_0(sw_write32_0), .sw_write32_0_valid(sw_write32_0_valid),
    .fw_read_data32_all(fw_read_data32_all), .fw_read_status32_all(fw_read_status32_all),
    .fw_dev_id_enable(fw_dev_id_enable), .fw_op_code_strobe(fw_op_code_strobe),
    .sw_write24_0(sw_write24_0), .sw_read32_0(sw_read32_0), .sw_read32_1(sw_read32_1),
    .cmd_count(cmd_count), .cmd_error(cmd_error)
  );

  always #5 fw_clk = ~fw_clk;

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge fw_clk);
    #1;
  endtask

  task automatic test_reset();
    fw_rst = 1'b1; sw_write32_0_valid = 1'b0; sw_write32_0 = '0;
    fw_read_data32_all = '0; fw_read_status32_all = '0;
    step(); step();
    fw_rst = 1'b0;
    n_tests++; if (fw_dev_id_enable !== 15'h0) begin n_fail++; $display("FAIL reset_enable got %h exp 0", fw_dev_id_enable); end
    n_tests++; if (fw_op_code_strobe !== 14'h0) begin n_fail++; $display("FAIL reset_strobe got %h exp 0", fw_op_code_strobe); end
    n_tests++; if (sw_write24_0 !== 24'h0) begin n_fail++; $display("FAIL reset_payload got %h exp 0", sw_write24_0); end
    n_tests++; if (sw_read32_0 !== 32'h0 || sw_read32_1 !== 32'h0) begin n_fail++; $display("FAIL reset_read got %h/%h exp 0/0", sw_read32_0, sw_read32_1); end
    n_tests++; if (cmd_count !== 16'h0 || cmd_error !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_err got %h/%b exp 0/0", cmd_count, cmd_error); end
  endtask

  task automatic test_decode_and_read();
    fw_read_data32_all[32*1 +: 32]   = 32'hDEADBEEF;
    fw_read_status32_all[32*1 +: 32] = 32'h12345678;
    step();
    n_tests++; if (sw_read32_0 !== 32'h0) begin n_fail++; $display("FAIL read_before_select got %h exp 0", sw_read32_0); end
    sw_write32_0 = 32'h2CABCDEF; sw_write32_0_valid = 1'b1;
    step();
    sw_write32_0_valid = 1'b0;
    n_tests++; if (fw_dev_id_enable !== 15'h0002) begin n_fail++; $display("FAIL dec_enable got %h exp 0002", fw_dev_id_enable); end
    n_tests++; if (fw_op_code_strobe !== 14'h1000) begin n_fail++; $display("FAIL dec_strobe got %h exp 1000", fw_op_code_strobe); end
    n_tests++; if (sw_write24_0 !== 24'hABCDEF) begin n_fail++; $display("FAIL dec_payload got %h exp abcdef", sw_write24_0); end
    n_tests++; if (cmd_count !== 16'd1 || cmd_error !== 1'b0) begin n_fail++; $display("FAIL dec_cnt_err got %h/%b exp 1/0", cmd_count, cmd_error); end
    n_tests++; if (sw_read32_0 !== 32'h0) begin n_fail++; $display("FAIL read_latency1 got %h exp 0", sw_read32_0); end
    step();
    n_tests++; if (fw_op_code_strobe !== 14'h0) begin n_fail++; $display("FAIL strobe_one_cycle got %h exp 0", fw_op_code_strobe); end
    n_tests++; if (sw_read32_0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got %h exp deadbeef", sw_read32_0); end
    n_tests++; if (sw_read32_1 !== 32'h12345678) begin n_fail++; $display("FAIL read_status got %h exp 12345678", sw_read32_1); end
    n_tests++; if (fw_dev_id_enable !== 15'h0002) begin n_fail++; $display("FAIL enable_level got %h exp 0002", fw_dev_id_enable); end
  endtask

  task automatic test_illegal();
    fw_read_data32_all[32*0 +: 32] = 32'hCAFEF00D;
    sw_write32_0 = 32'h01000000; sw_write32_0_valid = 1'b1;
    step();
    n_tests++; if (cmd_error !== 1'b1) begin n_fail++; $display("FAIL ill_dev0_error got %b exp 1", cmd_error); end
    n_tests++; if (fw_op_code_strobe !== 14'h0) begin n_fail++; $display("FAIL ill_dev0_strobe got %h exp 0", fw_op_code_strobe); end
    sw_write32_0 = 32'h1F000000;
    step();
    sw_write32_0_valid = 1'b0;
    n_tests++; if (cmd_error !== 1'b1 || fw_op_code_strobe !== 14'h0) begin n_fail++; $display("FAIL ill_op15 got err %b strobe %h exp 1/0", cmd_error, fw_op_code_strobe); end
    n_tests++; if (fw_dev_id_enable !== 15'h0002 || cmd_count !== 16'd1 || sw_write24_0 !== 24'hABCDEF) begin n_fail++; $display("FAIL ill_unchanged got %h/%h/%h exp 0002/0001/abcdef", fw_dev_id_enable, cmd_count, sw_write24_0); end
    n_tests++; if (sw_read32_0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ill_read_keep got %h exp deadbeef", sw_read32_0); end
    sw_write32_0 = 32'h1B000000; sw_write32_0_valid = 1'b1;
    step();
    sw_write32_0_valid = 1'b0;
    n_tests++; if (fw_op_code_strobe !== 14'h0800) begin n_fail++; $display("FAIL clr_strobe got %h exp 0800", fw_op_code_strobe); end
    n_tests++; if (cmd_error !== 1'b0) begin n_fail++; $display("FAIL clr_error got %b exp 0", cmd_error); end
    n_tests++; if (fw_dev_id_enable !== 15'h0001 || cmd_count !== 16'd2 || sw_write24_0 !== 24'h0) begin n_fail++; $display("FAIL clr_fields got %h/%h/%h exp 0001/0002/000000", fw_dev_id_enable, cmd_count, sw_write24_0); end
    step();
    n_tests++; if (sw_read32_0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL read_dev1 got %h exp cafef00d", sw_read32_0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cmds [3];
    cmds[0] = 32'h51000001; cmds[1] = 32'h52000002; cmds[2] = 32'h53000003;
    sw_write32_0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw_write32_0 = cmds[i];
      step();
      n_tests++; if (fw_op_code_strobe !== (14'd2 << i)) begin n_fail++; $display("FAIL b2b_strobe%0d got %h exp %h", i, fw_op_code_strobe, 14'd2 << i); end
      n_tests++; if (fw_dev_id_enable !== 15'h0010 || cmd_count !== 16'(3 + i) || sw_write24_0 !== 24'(i + 1)) begin n_fail++; $display("FAIL b2b_fields%0d got %h/%h/%h exp 0010/%h/%h", i, fw_dev_id_enable, cmd_count, sw_write24_0, 16'(3 + i), 24'(i + 1)); end
    end
    sw_write32_0 = 32'h3D000007;
    step();
    sw_write32_0_valid = 1'b0;
    n_tests++; if (fw_op_code_strobe !== 14'h0 || fw_dev_id_enable !== 15'h0004) begin n_fail++; $display("FAIL nop13 got strobe %h en %h exp 0/0004", fw_op_code_strobe, fw_dev_id_enable); end
    n_tests++; if (cmd_count !== 16'd6 || sw_write24_0 !== 24'h7) begin n_fail++; $display("FAIL nop13_cnt got %h/%h exp 0006/000007", cmd_count, sw_write24_0); end
    step();
    n_tests++; if (fw_op_code_strobe !== 14'h0) begin n_fail++; $display("FAIL b2b_idle got %h exp 0", fw_op_code_strobe); end
  endtask

  task automatic test_wrap();
    sw_write32_0 = 32'h41000000; sw_write32_0_valid = 1'b1;
    for (int i = 0; i < 65529; i++) @(posedge fw_clk);
    #1;
    sw_write32_0_valid = 1'b0;
    n_tests++; if (cmd_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got %h exp ffff", cmd_count); end
    sw_write32_0_valid = 1'b1;
    step();
    sw_write32_0_valid = 1'b0;
    n_tests++; if (cmd_count !== 16'h0000 || cmd_error !== 1'b0) begin n_fail++; $display("FAIL wrap got %h/%b exp 0000/0", cmd_count, cmd_error); end
  endtask

  task automatic test_reset_collision();
    sw_write32_0 = 32'h21000005; sw_write32_0_valid = 1'b1;
    step();
    n_tests++; if (fw_op_code_strobe !== 14'h0002) begin n_fail++; $display("FAIL pre_rst_strobe got %h exp 0002", fw_op_code_strobe); end
    fw_rst = 1'b1; sw_write32_0 = 32'h3C000001;
    step();
    fw_rst = 1'b0;
    n_tests++; if (fw_op_code_strobe !== 14'h0 || fw_dev_id_enable !== 15'h0 || sw_write24_0 !== 24'h0) begin n_fail++; $display("FAIL rst_coll_out got %h/%h/%h exp 0/0/0", fw_op_code_strobe, fw_dev_id_enable, sw_write24_0); end
    n_tests++; if (cmd_count !== 16'h0 || cmd_error !== 1'b0 || sw_read32_0 !== 32'h0 || sw_read32_1 !== 32'h0) begin n_fail++; $display("FAIL rst_coll_regs got %h/%b/%h/%h exp 0/0/0/0", cmd_count, cmd_error, sw_read32_0, sw_read32_1); end
    step();
    sw_write32_0_valid = 1'b0;
    n_tests++; if (fw_op_code_strobe !== 14'h1000 || fw_dev_id_enable !== 15'h0004) begin n_fail++; $display("FAIL post_rst_dec got %h/%h exp 1000/0004", fw_op_code_strobe, fw_dev_id_enable); end
    n_tests++; if (sw_write24_0 !== 24'h000001 || cmd_count !== 16'd1 || cmd_error !== 1'b0) begin n_fail++; $display("FAIL post_rst_fields got %h/%h/%b exp 000001/0001/0", sw_write24_0, cmd_count, cmd_error); end
  endtask

  initial begin
    test_reset();
    test_decode_and_read();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_reset_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_to_fw_cmd_decoder.md
# sw_to_fw_cmd_decoder

Sits between the AXI software register bank and the firmware IP instances; it is the stage that feeds each IP's device-enable, op-code strobes and write-payload inputs. Each software command word is decoded into a latched device select, a one-cycle op-code strobe and a registered 24-bit payload. The block also returns the selected IP's read-data and read-status words to software through registered multiplexers, and keeps a command counter and a sticky error flag.

## Interface
- NUM_FW, 15, number of firmware IPs attached (1..15)
- CNT_W, 16, width of accepted-command counter
- fw_clk  in  1  fw clock; all logic on rising edge
- fw_rst  in  1  reset, synchronous, active-high
- sw_write32_0  in  32  command word: [31:28] device id, [27:24] op code, [23:0] payload
- sw_write32_0_valid  in  1  one-cycle strobe: sw_write32_0 holds a new command
- fw_read_data32_all  in  32*NUM_FW  read-data of IP i on bits [32i+31:32i], i = dev id - 1
- fw_read_status32_all  in  32*NUM_FW  read-status, same packing
- fw_dev_id_enable  out  NUM_FW  one-hot level select of current device
- fw_op_code_strobe  out  14  one-hot one-cycle op strobes, index = op code: 0 w_reset, 1 w_cfg_static_0, 2 r_cfg_static_0, 3 w_cfg_static_1, 4 r_cfg_static_1, 5 w_cfg_array_0, 6 r_cfg_array_0, 7 w_cfg_array_1, 8 r_cfg_array_1, 9 r_data_array_0, 10 r_data_array_1, 11 w_status_clear, 12 w_execute, 13 reserved_nop
- sw_write24_0  out  24  registered payload of last accepted command
- sw_read32_0  out  32  registered read-data of selected IP
- sw_read32_1  out  32  registered read-status of selected IP
- cmd_count  out  CNT_W  accepted commands, wraps
- cmd_error  out  1  sticky illegal-command flag

## Operation
- A command is accepted when valid=1, 1 <= dev id <= NUM_FW and op code <= 13.
- On acceptance: dev_sel register <- dev id; fw_dev_id_enable <- one-hot(dev id - 1); strobe bit [op] pulses; sw_write24_0 <- payload; cmd_count <- cmd_count + 1, mod 2^CNT_W.
- Op 13 is accepted and counted. It changes the selection but its strobe bit is driven 0 (nop).
- Illegal command: valid=1 with dev id 0, dev id > NUM_FW, or op code 14/15. Effects:
  - cmd_error <- 1.
  - No strobe; enable, payload and count unchanged.
- cmd_error clears only on an accepted op 11 (w_status_clear), on any device, and on reset. Set has priority only if the same cycle is illegal; the two cannot coincide.
- Read mux:
  - sw_read32_0 <- slice [dev_sel-1] of fw_read_data32_all, every cycle; 0 when dev_sel = 0 (after reset).
  - sw_read32_1 likewise from fw_read_status32_all.
- Back-to-back valid every cycle is legal. Each command is decoded independently; there is no backpressure.
- Reset values: fw_dev_id_enable 0, fw_op_code_strobe 0, sw_write24_0 0, sw_read32_0/1 0, cmd_count 0, cmd_error 0, dev_sel 0.

## Timing
- Command valid at edge N → enable, strobe, payload, count and error are all updated at N+1.
- The strobe is high for exactly the single cycle N+1..N+2 unless another accepted command follows.
- Read mux: sw_read32_x at edge k reflects the input slice at edge k-1 under dev_sel at k-1. After a selection change at N+1, the new device's data is visible at N+2.
- Reset asserted at edge N has priority over a simultaneous valid: all outputs are 0 at N+1 and the command is dropped. A strobe in flight is cut to 0.
- Counter wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Reset, then write 0x2C_ABCDEF with valid → enable = 0x0002; strobe[12] high for one cycle; sw_write24_0 = 0xABCDEF; cmd_count = 1; cmd_error = 0.
- Drive fw_read_data32_all slice 1 = 0xDEADBEEF after selecting dev 2 → sw_read32_0 = 0xDEADBEEF two cycles after the command edge; reads 0 before any select.
- Send 0x0100_0000 (dev 0), then 0x1F00_0000 (op 15) → cmd_error = 1; enable, count and payload unchanged; no strobe. Then send 0x1B00_0000 → strobe[11] pulse and cmd_error = 0.
- Apply valid on 3 consecutive cycles with ops 1, 2, 3 on dev 5 → strobe bits 1, 2, 3 in consecutive cycles; cmd_count +3; enable = 0x0010 throughout.
- Preload cmd_count to 0xFFFF via 65535 commands (or force) and send one more → cmd_count = 0x0000.
- Assert fw_rst in the same cycle as valid 0x3C_000001 → next cycle all outputs 0 and no strobe; the command following reset decodes normally.
